// File: rtl/boot_pkg.sv
// Shared definitions for the serial ROM boot loader: FSM states and word/byte widths.
package boot_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM
  } boot_state_t;

endpackage

// File: rtl/boot_word_packer.sv
// Packs a byte stream into little-endian 32-bit words; word_valid pulses the cycle after the 4th byte.
module boot_word_packer
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              last_lane,
  output logic [INST_W-1:0] word,
  output logic              word_valid
);

  logic [1:0]        lane_q;
  logic [INST_W-1:0] shreg_q;

  assign last_lane = (lane_q == 2'd3);

  // Bytes shift in from the top so the first byte ends up in bits [7:0].
  // word only updates on completion, so it holds between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q     <= '0;
      shreg_q    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane_q <= '0;
      end else if (byte_valid) begin
        shreg_q <= {byte_data, shreg_q[INST_W-1:BYTE_W]};
        lane_q  <= lane_q + 2'd1;
        if (last_lane) begin
          word       <= {byte_data, shreg_q[INST_W-1:BYTE_W]};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rom_boot_loader.sv
// Serial-download controller: UART bytes -> ROM words, holding the core in reset until the checksum matches.
module rom_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid_i,
  input  logic [BYTE_W-1:0] rx_data_i,
  output logic              rom_wen_o,
  output logic [31:0]       rom_w_addr_o,
  output logic [INST_W-1:0] rom_w_data_o,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC + 1);

  boot_state_t state_q, state_nxt;

  logic [15:0]      count_q;
  logic [15:0]      word_idx_q;
  logic [7:0]       csum_q;
  logic [GAP_W-1:0] gap_q;
  logic [31:0]      addr_q;
  logic             core_rst_q, err_q, done_q;

  logic        start_load, load_ok, load_err, data_byte, timeout;
  logic        last_lane;
  logic [15:0] count_full;

  assign count_full = {rx_data_i, count_q[7:0]};

  boot_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_load),
    .byte_valid (data_byte),
    .byte_data  (rx_data_i),
    .last_lane  (last_lane),
    .word       (rom_w_data_o),
    .word_valid (rom_wen_o)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt  = state_q;
    start_load = 1'b0;
    load_ok    = 1'b0;
    load_err   = 1'b0;
    data_byte  = 1'b0;
    timeout    = (state_q != ST_IDLE) && !rx_valid_i &&
                 (gap_q == GAP_W'(TIMEOUT_CYC - 1));
    case (state_q)
      ST_IDLE: begin
        if (rx_valid_i && rx_data_i == SYNC_BYTE) begin
          state_nxt  = ST_LEN0;
          start_load = 1'b1;
        end
      end
      ST_LEN0: if (rx_valid_i) state_nxt = ST_LEN1;
      ST_LEN1: begin
        if (rx_valid_i) begin
          if (32'(count_full) > 32'(DEPTH_WORDS)) begin
            state_nxt = ST_IDLE;
            load_err  = 1'b1;
          end else if (count_full == 16'd0) begin
            state_nxt = ST_CSUM;
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid_i) begin
          data_byte = 1'b1;
          if (last_lane && word_idx_q == count_q - 16'd1) state_nxt = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (rx_valid_i) begin
          state_nxt = ST_IDLE;
          if (rx_data_i == csum_q) load_ok  = 1'b1;
          else                     load_err = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (timeout) begin
      state_nxt = ST_IDLE;
      load_err  = 1'b1;
    end
  end

  always_comb begin
    busy_o       = (state_q != ST_IDLE);
    rom_w_addr_o = addr_q;
    core_rst_o   = core_rst_q;
    done_o       = done_q;
    err_o        = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      word_idx_q <= '0;
      csum_q     <= '0;
      gap_q      <= '0;
      addr_q     <= '0;
      core_rst_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= load_ok;
      if (rx_valid_i || state_nxt == ST_IDLE) gap_q <= '0;
      else                                    gap_q <= gap_q + GAP_W'(1);
      if (start_load) begin
        err_q      <= 1'b0;
        core_rst_q <= 1'b1;
        csum_q     <= '0;
        word_idx_q <= '0;
      end
      if (load_err) err_q      <= 1'b1;
      if (load_ok)  core_rst_q <= 1'b0;
      if (state_q == ST_LEN0 && rx_valid_i) count_q[7:0]  <= rx_data_i;
      if (state_q == ST_LEN1 && rx_valid_i) count_q[15:8] <= rx_data_i;
      if (data_byte) begin
        csum_q <= csum_q + rx_data_i;
        // Address is latched on the same edge the packer latches its word.
        if (last_lane) begin
          addr_q     <= BASE_ADDR + {14'd0, word_idx_q, 2'b00};
          word_idx_q <= word_idx_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_boot_loader.sv
// Directed bench for rom_boot_loader with a short timeout so the idle-gap path is reachable.
module tb_rom_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rom_wen_o;
  logic [31:0] rom_w_addr_o;
  logic [31:0] rom_w_data_o;
  logic        core_rst_o, busy_o, done_o, err_o;

  int checks = 0;
  int errors = 0;

  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];

  rom_boot_loader #(
    .DEPTH_WORDS (4096),
    .BASE_ADDR   (32'h0000_0000),
    .TIMEOUT_CYC (100),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid_i   (rx_valid_i),
    .rx_data_i    (rx_data_i),
    .rom_wen_o    (rom_wen_o),
    .rom_w_addr_o (rom_w_addr_o),
    .rom_w_data_o (rom_w_data_o),
    .core_rst_o   (core_rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rom_wen_o) begin
      if (wr_cnt < 8) begin
        wr_addr[wr_cnt] = rom_w_addr_o;
        wr_data[wr_cnt] = rom_w_data_o;
      end
      wr_cnt++;
    end
    if (done_o) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic send_frame(input logic [7:0] csum);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    send_byte(csum);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    idle(3);
    checks++;
    if ({rom_wen_o, rom_w_addr_o, rom_w_data_o, core_rst_o, busy_o, done_o, err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wen=%b addr=%h data=%h crst=%b busy=%b done=%b err=%b exp all 0",
               rom_wen_o, rom_w_addr_o, rom_w_data_o, core_rst_o, busy_o, done_o, err_o);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic_load();
    clear_log();
    send_byte(8'hA5);
    checks++;
    if (core_rst_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL sync_start got crst=%b busy=%b exp 1 1", core_rst_o, busy_o);
    end
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    checks++;
    if (rom_wen_o !== 1'b1 || rom_w_addr_o !== 32'h0 || rom_w_data_o !== 32'h44332211) begin
      errors++; $display("FAIL word0_write got wen=%b addr=%h data=%h exp 1 00000000 44332211",
                         rom_wen_o, rom_w_addr_o, rom_w_data_o);
    end
    send_byte(8'h55);
    checks++;
    if (rom_wen_o !== 1'b0 || rom_w_data_o !== 32'h44332211 || rom_w_addr_o !== 32'h0) begin
      errors++; $display("FAIL word0_hold got wen=%b addr=%h data=%h exp 0 00000000 44332211",
                         rom_wen_o, rom_w_addr_o, rom_w_data_o);
    end
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    checks++;
    if (rom_wen_o !== 1'b1 || rom_w_addr_o !== 32'h4 || rom_w_data_o !== 32'h88776655) begin
      errors++; $display("FAIL word1_write got wen=%b addr=%h data=%h exp 1 00000004 88776655",
                         rom_wen_o, rom_w_addr_o, rom_w_data_o);
    end
    send_byte(8'h64);
    checks++;
    if (done_o !== 1'b1 || core_rst_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL basic_done got done=%b crst=%b err=%b busy=%b exp 1 0 0 0",
                         done_o, core_rst_o, err_o, busy_o);
    end
    idle(1);
    checks++;
    if (done_o !== 1'b0 || done_cnt !== 1 || wr_cnt !== 2) begin
      errors++; $display("FAIL basic_counts got done=%b done_cnt=%0d wr_cnt=%0d exp 0 1 2",
                         done_o, done_cnt, wr_cnt);
    end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    send_frame(8'h65);
    idle(1);
    checks++;
    if (err_o !== 1'b1 || core_rst_o !== 1'b1 || done_cnt !== 0 || wr_cnt !== 2 ||
        wr_data[1] !== 32'h88776655 || wr_addr[1] !== 32'h4) begin
      errors++; $display("FAIL bad_csum got err=%b crst=%b done_cnt=%0d wr_cnt=%0d d1=%h a1=%h exp 1 1 0 2 88776655 00000004",
                         err_o, core_rst_o, done_cnt, wr_cnt, wr_data[1], wr_addr[1]);
    end
  endtask

  task automatic test_oversize();
    clear_log();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || wr_cnt !== 0) begin
      errors++; $display("FAIL oversize got err=%b busy=%b wr_cnt=%0d exp 1 0 0", err_o, busy_o, wr_cnt);
    end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL max_count got err=%b busy=%b exp 0 1", err_o, busy_o);
    end
    rst = 1'b1; idle(1); rst = 1'b0; idle(1);
  endtask

  task automatic test_timeout();
    clear_log();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    idle(99);
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL timeout_early got err=%b busy=%b exp 0 1", err_o, busy_o);
    end
    idle(1);
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || wr_cnt !== 0 || core_rst_o !== 1'b1) begin
      errors++; $display("FAIL timeout_hit got err=%b busy=%b wr_cnt=%0d crst=%b exp 1 0 0 1",
                         err_o, busy_o, wr_cnt, core_rst_o);
    end
    send_frame(8'h64);
    idle(1);
    checks++;
    if (err_o !== 1'b0 || core_rst_o !== 1'b0 || done_cnt !== 1 || wr_cnt !== 2) begin
      errors++; $display("FAIL timeout_recover got err=%b crst=%b done_cnt=%0d wr_cnt=%0d exp 0 0 1 2",
                         err_o, core_rst_o, done_cnt, wr_cnt);
    end
  endtask

  task automatic test_zero_length();
    clear_log();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    checks++;
    if (busy_o !== 1'b0 || core_rst_o !== 1'b0) begin
      errors++; $display("FAIL noise got busy=%b crst=%b exp 0 0", busy_o, core_rst_o);
    end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if (done_o !== 1'b1 || wr_cnt !== 0 || core_rst_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL zero_len got done=%b wr_cnt=%0d crst=%b err=%b exp 1 0 0 0",
                         done_o, wr_cnt, core_rst_o, err_o);
    end
  endtask

  task automatic test_sync_in_data();
    clear_log();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'hA5); send_byte(8'hA5); send_byte(8'hA5);
    send_byte(8'h94);
    idle(1);
    checks++;
    if (wr_cnt !== 1 || wr_data[0] !== 32'hA5A5A5A5 || wr_addr[0] !== 32'h0 || done_cnt !== 1 || err_o !== 1'b0) begin
      errors++; $display("FAIL sync_as_data got wr_cnt=%0d d0=%h a0=%h done_cnt=%0d err=%b exp 1 a5a5a5a5 00000000 1 0",
                         wr_cnt, wr_data[0], wr_addr[0], done_cnt, err_o);
    end
  endtask

  task automatic test_back_to_back_reset();
    clear_log();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    checks++;
    if (core_rst_o !== 1'b1 || busy_o !== 1'b1 || wr_cnt !== 1) begin
      errors++; $display("FAIL midload_pre got crst=%b busy=%b wr_cnt=%0d exp 1 1 1", core_rst_o, busy_o, wr_cnt);
    end
    rst = 1'b1;
    send_byte(8'h77);
    checks++;
    if ({rom_wen_o, rom_w_addr_o, rom_w_data_o, core_rst_o, busy_o, done_o, err_o} !== '0) begin
      errors++; $display("FAIL midload_rst got wen=%b addr=%h data=%h crst=%b busy=%b done=%b err=%b exp all 0",
                         rom_wen_o, rom_w_addr_o, rom_w_data_o, core_rst_o, busy_o, done_o, err_o);
    end
    rst = 1'b0;
    clear_log();
    send_frame(8'h64);
    idle(1);
    checks++;
    if (wr_cnt !== 2 || wr_data[0] !== 32'h44332211 || wr_data[1] !== 32'h88776655 ||
        done_cnt !== 1 || core_rst_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL after_rst_load got wr_cnt=%0d d0=%h d1=%h done_cnt=%0d crst=%b err=%b exp 2 44332211 88776655 1 0 0",
                         wr_cnt, wr_data[0], wr_data[1], done_cnt, core_rst_o, err_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_bad_checksum();
    test_oversize();
    test_timeout();
    test_zero_length();
    test_sync_in_data();
    test_back_to_back_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
